fpu_cmd_issuer: RTL
===================

Name: fpu_cmd_issuer

Overview:
- Front-end stage that sits directly upstream of the FPU top and buffers floating-point commands (opcode, A, B) from a producer in a small FIFO.
- Issues one command at a time to the FPU using its start/done protocol and captures each result into a single-entry response register with a valid/ready handshake.
- A watchdog aborts any FPU operation that never signals done.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, ≥2.
- TIMEOUT, 64, maximum WAIT cycles before abort; ≥1.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  producer presents a command
- cmd_ready  out  1  FIFO can accept; equals (count != DEPTH)
- cmd_opcode  in  4  FPU opcode
- cmd_a  in  32  operand A, IEEE-754 single
- cmd_b  in  32  operand B
- fpu_start  out  1  one-cycle start pulse to FPU
- fpu_opcode  out  4  FIFO head opcode
- fpu_a  out  32  FIFO head operand A
- fpu_b  out  32  FIFO head operand B
- fpu_result  in  32  FPU result_out
- fpu_done  in  1  FPU done
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  32  captured result
- rsp_opcode  out  4  opcode of that result
- rsp_err  out  1  response produced by timeout
- occupancy  out  clog2(DEPTH)+1  FIFO entry count

Behaviour:
- Reset: all state clears synchronously.
  - FIFO empty, occupancy=0, cmd_ready=1.
  - State IDLE, fpu_start=0.
  - rsp_valid=0, rsp_result=0, rsp_opcode=0, rsp_err=0.
  - Watchdog counter=0.
- Push: occurs when cmd_valid && cmd_ready; entry is visible in occupancy next cycle.
- cmd_ready depends only on registered count. When the FIFO is full, a pop in the same cycle does NOT allow a push.
- Simultaneous push and pop when not full: occupancy is unchanged; pointers wrap modulo DEPTH.
- fpu_opcode/fpu_a/fpu_b are always driven from the FIFO head. They stay stable from ISSUE through WAIT until the pop.
- FSM (registered state):
  - IDLE: if occupancy != 0 && !rsp_valid, go to ISSUE. Otherwise stay.
  - ISSUE: fpu_start=1 for exactly this cycle. Clear the watchdog. fpu_done is ignored in this cycle. Always go to WAIT.
  - WAIT, fpu_done=1 this cycle:
    - Next cycle: rsp_result=fpu_result sampled this cycle, rsp_opcode=head opcode, rsp_err=0, rsp_valid=1.
    - Pop the head; go to IDLE.
  - WAIT, fpu_done=0 with watchdog == TIMEOUT-1:
    - Next cycle: rsp_result=32'h7FC00000 (qNaN), rsp_err=1, rsp_valid=1.
    - Pop the head; go to IDLE.
  - WAIT, otherwise: watchdog increments by 1.
- fpu_done is ignored in IDLE and ISSUE. A late done from an aborted op is therefore discarded.
- Response register: holds its value while rsp_valid && !rsp_ready. It clears rsp_valid on rsp_valid && rsp_ready.
- Issue is blocked while rsp_valid=1. Exactly one op is in flight; no response is ever overwritten.
- Latency:
  - Push in cycle N into an empty, idle block gives fpu_start in cycle N+2.
  - fpu_done in cycle D gives rsp_valid in cycle D+1.
  - With rsp_ready held high, the next IDLE→ISSUE decision is made in cycle D+2.
- Reset mid-WAIT: the outstanding op is abandoned and queued commands are discarded. No fpu_start pulse occurs in the reset cycle or the cycle after.

Test Plan:
- Single op:
  - Push opcode=0, A=0x3F800000, B=0x40000000.
  - FPU model returns 0x40400000 with done 5 cycles after start.
  - Expect: fpu_start one pulse 2 cycles after push; rsp_valid=1 with rsp_result=0x40400000, rsp_err=0, one cycle after done.
- Fill and order:
  - Push 5 commands back-to-back with DEPTH=4 and a stalled FPU.
  - Expect: cmd_ready=0 after 4 accepted, occupancy=4, the 5th is held by the producer.
  - Responses return in push order with matching rsp_opcode.
- Backpressure:
  - Hold rsp_ready=0 after the first response with 2 queued.
  - Expect: rsp_* is stable and no fpu_start occurs until rsp_ready=1; the next fpu_start follows 2 cycles after the handshake.
- Timeout:
  - FPU never asserts done, TIMEOUT=64.
  - Expect: rsp_valid with rsp_result=0x7FC00000, rsp_err=1, 64 cycles after the ISSUE cycle ends.
  - A later stray fpu_done in IDLE is ignored.
- Reset mid-WAIT:
  - Assert rst for 1 cycle during WAIT with 3 entries queued.
  - Expect: occupancy=0, rsp_valid=0, fpu_start=0, cmd_ready=1 the cycle after rst.
  - An fpu_done arriving afterwards produces no response.
- Full with simultaneous pop:
  - FIFO full, fpu_done pops the head while cmd_valid=1.
  - Expect: no push that cycle; occupancy=3 next cycle with cmd_ready=1; push accepted in the following cycle.

Source files
------------

// File: rtl/fpu_cmd_issuer.sv
// Buffers FPU commands in a small FIFO and issues them one at a time over the FPU
// start/done protocol, holding each result in a single-entry response register.
module fpu_cmd_issuer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [3:0]               cmd_opcode_i,
  input  logic [31:0]              cmd_a_i,
  input  logic [31:0]              cmd_b_i,
  output logic                     fpu_start_o,
  output logic [3:0]               fpu_opcode_o,
  output logic [31:0]              fpu_a_o,
  output logic [31:0]              fpu_b_o,
  input  logic [31:0]              fpu_result_i,
  input  logic                     fpu_done_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [31:0]              rsp_result_o,
  output logic [3:0]               rsp_opcode_o,
  output logic                     rsp_err_o,
  output logic [$clog2(DEPTH):0]   occupancy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [WW-1:0] LAST = WW'(TIMEOUT - 1);
  localparam logic [31:0]   QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  cmd_t          mem_q [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop, timeout;

  state_e        state_q, state_d;
  logic [WW-1:0] wdog_q, wdog_d;

  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_result_q, rsp_result_d;
  logic [3:0]    rsp_opcode_q, rsp_opcode_d;
  logic          rsp_err_q, rsp_err_d;

  // Ready looks only at the registered count, so a pop never frees a slot in the same cycle.
  assign cmd_ready_o = (count_q != FULL);
  assign push        = cmd_valid_i && cmd_ready_o;
  assign head        = mem_q[rd_ptr_q];

  assign fpu_opcode_o = head.op;
  assign fpu_a_o      = head.a;
  assign fpu_b_o      = head.b;
  assign occupancy_o  = count_q;

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_opcode_o = rsp_opcode_q;
  assign rsp_err_o    = rsp_err_q;

  always_comb begin
    state_d     = state_q;
    wdog_d      = wdog_q;
    fpu_start_o = 1'b0;
    pop         = 1'b0;
    timeout     = 1'b0;
    unique case (state_q)
      IDLE: if (count_q != '0 && !rsp_valid_q) state_d = ISSUE;
      ISSUE: begin
        fpu_start_o = 1'b1;
        wdog_d      = '0;
        state_d     = WAIT;
      end
      WAIT: begin
        if (fpu_done_i) begin
          pop     = 1'b1;
          state_d = IDLE;
        end else if (wdog_q == LAST) begin
          pop     = 1'b1;
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // A pop can only happen with the response slot empty, since issue waits on it.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_opcode_d = rsp_opcode_q;
    rsp_err_d    = rsp_err_q;
    if (rsp_valid_q && rsp_ready_i) rsp_valid_d = 1'b0;
    if (pop) begin
      rsp_valid_d  = 1'b1;
      rsp_result_d = timeout ? QNAN : fpu_result_i;
      rsp_opcode_d = head.op;
      rsp_err_d    = timeout;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      wdog_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_opcode_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wdog_q       <= wdog_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_opcode_q <= rsp_opcode_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Storage needs no reset: an entry is only observed once count covers it.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) mem_q[wr_ptr_q] <= '{op: cmd_opcode_i, a: cmd_a_i, b: cmd_b_i};
  end

endmodule
